alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of alarm slots (1..16).
REQ-002 Parameter RING_SECONDS, default 60, ring duration in sec_tick pulses before auto-stop.
REQ-003 Parameter SNOOZE_MINUTES, default 5, snooze delay in minutes (1..59).
REQ-004 Parameter SW = max(1, clog2(NUM_ALARMS)), slot index width.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 sec_tick  input  1  one-cycle pulse per second.
REQ-008 cur_hours  input  5  current time hours, 0..23.
REQ-009 cur_minutes  input  6  current minutes, 0..59.
REQ-010 cur_seconds  input  6  current seconds, 0..59.
REQ-011 wr_en  input  1  one-cycle write strobe into slot wr_sel.
REQ-012 wr_sel  input  SW  target slot of write.
REQ-013 dispMode  input  1  1 = write uses 12 h fields, 0 = 24 h fields.
REQ-014 wr_isPM, wr_hours12[3:0], wr_hours24[4:0], wr_minutes[5:0]  input  write data.
REQ-015 snooze, dismiss  input  1 each  one-cycle user pulses.
REQ-016 rd_sel  input  SW; rd_hours output 5, rd_minutes output 6  combinational slot readback.
REQ-017 ringing  output  1  high while state RINGING.
REQ-018 snoozed  output  1  high while state SNOOZED.
REQ-019 ring_id  output  SW  slot that caused current ring/snooze; 0 in IDLE.

Function
REQ-020 Each slot SHALL store hours (5 b) and minutes (6 b); hours == 24 means slot disabled, never matches.
REQ-021 On wr_en with dispMode=1, stored hours SHALL be 12*wr_isPM when wr_hours12==12, else 12*wr_isPM + wr_hours12; minutes = wr_minutes.
REQ-022 On wr_en with dispMode=0, stored hours SHALL be wr_hours24, minutes = wr_minutes; wr_hours24==24 disables slot.
REQ-023 A write SHALL be ignored when wr_hours12 is 0 or >12 (12 h), wr_hours24 >24 (24 h), wr_minutes >59, or wr_sel >= NUM_ALARMS.
REQ-024 Written value SHALL be visible on rd_* the cycle after the write edge.
REQ-025 Match SHALL be evaluated only on cycles with sec_tick=1 and cur_seconds==0: slot matches if enabled and hours==cur_hours and minutes==cur_minutes.
REQ-026 Multiple simultaneous matches: lowest slot index SHALL win; others dropped.
REQ-027 States: IDLE, RINGING, SNOOZED; reset state IDLE.
REQ-028 IDLE -> RINGING on match; ring_id = winner, ring counter = 0; ringing asserts the cycle after the match edge.
REQ-029 RINGING: ring counter increments per sec_tick; on reaching RING_SECONDS -> IDLE.
REQ-030 RINGING + snooze -> SNOOZED, snooze counter loaded with SNOOZE_MINUTES*60.
REQ-031 SNOOZED: counter decrements per sec_tick; when it reaches 0 -> RINGING with same ring_id, ring counter = 0.
REQ-032 dismiss in RINGING or SNOOZED -> IDLE; dismiss beats snooze in the same cycle; both ignored in IDLE.
REQ-033 Matches in RINGING SHALL be ignored; a match in SNOOZED SHALL cancel snooze and enter RINGING with the new ring_id.
REQ-034 Rewriting or disabling the active slot SHALL NOT alter current RINGING/SNOOZED state.
REQ-035 A write and match to the same slot in one cycle: match uses the pre-write value.

Reset
REQ-036 reset SHALL asynchronously set all slots to hours 24, minutes 0, state IDLE, counters 0, ringing=0, snoozed=0, ring_id=0.
REQ-037 reset mid-ring or mid-snooze SHALL drop to IDLE without a further ring.

Verification
REQ-038 Write slot 1 dispMode=1 isPM=0 hours12=12 min=30; cur 00:30:00 with sec_tick -> rd_hours=0, ringing=1, ring_id=1 next cycle.
REQ-039 Slots 2 and 0 both 07:15 (24 h); cur 07:15:00 tick -> ring_id=0; 60 ticks later ringing=0, no snooze.
REQ-040 Ringing slot 3, snooze pulse -> snoozed=1; 300 ticks -> ringing=1, ring_id=3; then snooze+dismiss same cycle -> IDLE.
REQ-041 Writes hours12=13, hours24=25, minutes=60 -> slot contents unchanged on readback.
REQ-042 Reset asserted during SNOOZED, released before counter expiry -> ringing stays 0, all rd_hours=24.

Source files
------------

// File: rtl/alarm_bank.sv
// alarm_bank: a bank of alarm slots compared against the running time of day.
// A shared ring/snooze state machine owns at most one active alarm at a time.
// Each slot holds hours/minutes in 24 h form; hours == 24 marks a slot as
// disabled. The machine rings for RING_SECONDS ticks. A snooze postpones the
// ring by SNOOZE_MINUTES minutes, and a dismiss ends it.
//
// Interface timing: this block has no valid/ready handshakes. wr_en, sec_tick,
// snooze and dismiss are single-cycle pulses that are sampled on the rising
// clk edge. rd_* is a purely combinational view of the stored slots.
module alarm_bank #(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int SW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sec_tick,
  input  logic [4:0]    cur_hours,
  input  logic [5:0]    cur_minutes,
  input  logic [5:0]    cur_seconds,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_sel,
  input  logic          dispMode,
  input  logic          wr_isPM,
  input  logic [3:0]    wr_hours12,
  input  logic [4:0]    wr_hours24,
  input  logic [5:0]    wr_minutes,
  input  logic          snooze,
  input  logic          dismiss,
  input  logic [SW-1:0] rd_sel,
  output logic [4:0]    rd_hours,
  output logic [5:0]    rd_minutes,
  output logic          ringing,
  output logic          snoozed,
  output logic [SW-1:0] ring_id,
  output logic [1:0]    fsm_state
);

  localparam int SNOOZE_LOAD = SNOOZE_MINUTES * 60;
  localparam int RW          = $clog2(RING_SECONDS + 1);
  localparam int NW          = $clog2(SNOOZE_LOAD + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [NW-1:0] SNZ_LOAD  = NW'(SNOOZE_LOAD);
  localparam logic [4:0]    HOURS_OFF = 5'd24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  // Slot storage
  logic [4:0] slot_hours   [NUM_ALARMS];
  logic [5:0] slot_minutes [NUM_ALARMS];

  // Write decode
  logic       wr_valid;
  logic [4:0] wr_hours;
  logic [4:0] pm_base;

  // Match result
  logic          match_hit;
  logic [SW-1:0] match_id;

  // FSM state and counters
  state_t        state, next_state;
  logic [RW-1:0] ring_cnt, ring_cnt_n;
  logic [NW-1:0] snz_cnt, snz_cnt_n;
  logic [SW-1:0] ring_id_q, ring_id_n;

  // Convert the write fields to 24 h form and reject any out-of-range field.
  // Hour 12 in 12 h mode is the start of its half-day: 12 AM -> 0, 12 PM -> 12.
  always_comb begin
    wr_valid = 1'b0;
    wr_hours = HOURS_OFF;
    pm_base  = wr_isPM ? 5'd12 : 5'd0;
    if (dispMode) begin
      wr_valid = (wr_hours12 != 4'd0) && (wr_hours12 <= 4'd12) && (wr_minutes <= 6'd59);
      wr_hours = (wr_hours12 == 4'd12) ? pm_base : (pm_base + {1'b0, wr_hours12});
    end else begin
      wr_valid = (wr_hours24 <= 5'd24) && (wr_minutes <= 6'd59);
      wr_hours = wr_hours24;
    end
  end

  // Slot registers. A wr_sel with no matching slot index simply writes nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hours[i]   <= HOURS_OFF;
        slot_minutes[i] <= 6'd0;
      end
    end else if (wr_en && wr_valid) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_sel == SW'(i)) begin
          slot_hours[i]   <= wr_hours;
          slot_minutes[i] <= wr_minutes;
        end
      end
    end
  end

  // Combinational readback. An index with no slot reads back as disabled.
  always_comb begin
    rd_hours   = HOURS_OFF;
    rd_minutes = 6'd0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_sel == SW'(i)) begin
        rd_hours   = slot_hours[i];
        rd_minutes = slot_minutes[i];
      end
    end
  end

  // Match only on the tick that starts a new minute. Scanning from the top
  // down lets the lowest matching index win. The scan reads registered slot
  // contents, so a same-cycle write to a slot does not affect this match.
  always_comb begin
    match_hit = 1'b0;
    match_id  = '0;
    if (sec_tick && (cur_seconds == 6'd0)) begin
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
        if ((slot_hours[i] != HOURS_OFF) &&
            (slot_hours[i] == cur_hours) &&
            (slot_minutes[i] == cur_minutes)) begin
          match_hit = 1'b1;
          match_id  = SW'(i);
        end
      end
    end
  end

  // State register together with the counters and the active slot id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      ring_id_q <= '0;
    end else begin
      state     <= next_state;
      ring_cnt  <= ring_cnt_n;
      snz_cnt   <= snz_cnt_n;
      ring_id_q <= ring_id_n;
    end
  end

  // Next-state logic. Priority within a cycle is dismiss, then snooze or a new
  // match, then counting on sec_tick. Slot writes never touch this state.
  always_comb begin
    next_state = state;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    ring_id_n  = ring_id_q;
    case (state)
      IDLE: begin
        if (match_hit) begin
          next_state = RINGING;
          ring_id_n  = match_id;
          ring_cnt_n = '0;
        end
      end
      RINGING: begin
        if (dismiss) begin
          next_state = IDLE;
          ring_cnt_n = '0;
          snz_cnt_n  = '0;
          ring_id_n  = '0;
        end else if (snooze) begin
          next_state = SNOOZED;
          snz_cnt_n  = SNZ_LOAD;
          ring_cnt_n = '0;
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) begin
            next_state = IDLE;
            ring_cnt_n = '0;
            ring_id_n  = '0;
          end else begin
            ring_cnt_n = ring_cnt + RW'(1);
          end
        end
      end
      SNOOZED: begin
        if (dismiss) begin
          next_state = IDLE;
          ring_cnt_n = '0;
          snz_cnt_n  = '0;
          ring_id_n  = '0;
        end else if (match_hit) begin
          next_state = RINGING;
          ring_id_n  = match_id;
          ring_cnt_n = '0;
          snz_cnt_n  = '0;
        end else if (sec_tick) begin
          if (snz_cnt <= NW'(1)) begin
            next_state = RINGING;
            ring_cnt_n = '0;
            snz_cnt_n  = '0;
          end else begin
            snz_cnt_n = snz_cnt - NW'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        ring_cnt_n = '0;
        snz_cnt_n  = '0;
        ring_id_n  = '0;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    ringing   = (state == RINGING);
    snoozed   = (state == SNOOZED);
    ring_id   = ring_id_q;
    fsm_state = state;
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed testbench for alarm_bank, using the default parameters (4 slots,
// 60 s ring, 5 min snooze). Inputs change 1 ns after each rising edge, and
// outputs are checked at that same point.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic       dispMode;
  logic       wr_isPM;
  logic [3:0] wr_hours12;
  logic [4:0] wr_hours24;
  logic [5:0] wr_minutes;
  logic       snooze;
  logic       dismiss;
  logic [1:0] rd_sel;
  logic [4:0] rd_hours;
  logic [5:0] rd_minutes;
  logic       ringing;
  logic       snoozed;
  logic [1:0] ring_id;
  logic [1:0] fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  alarm_bank dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .wr_en(wr_en), .wr_sel(wr_sel), .dispMode(dispMode), .wr_isPM(wr_isPM),
    .wr_hours12(wr_hours12), .wr_hours24(wr_hours24), .wr_minutes(wr_minutes),
    .snooze(snooze), .dismiss(dismiss), .rd_sel(rd_sel),
    .rd_hours(rd_hours), .rd_minutes(rd_minutes),
    .ringing(ringing), .snoozed(snoozed), .ring_id(ring_id), .fsm_state(fsm_state)
  );

  // Clock and cycle pacing
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic r, input logic s, input int id);
    check({tag, "_ringing"}, 32'(ringing), 32'(r));
    check({tag, "_snoozed"}, 32'(snoozed), 32'(s));
    check({tag, "_ring_id"}, 32'(ring_id), 32'(id));
  endtask

  task automatic check_rd(input string tag, input int sel, input int h, input int m);
    rd_sel = 2'(sel);
    #1;
    check({tag, "_hours"}, 32'(rd_hours), 32'(h));
    check({tag, "_minutes"}, 32'(rd_minutes), 32'(m));
  endtask

  // Drivers
  task automatic write12(input int sel, input logic pm, input int h12, input int m);
    wr_en = 1'b1; wr_sel = 2'(sel); dispMode = 1'b1; wr_isPM = pm;
    wr_hours12 = 4'(h12); wr_minutes = 6'(m);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic write24(input int sel, input int h24, input int m);
    wr_en = 1'b1; wr_sel = 2'(sel); dispMode = 1'b0;
    wr_hours24 = 5'(h24); wr_minutes = 6'(m);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  // Ticks with non-zero seconds, so they only advance the counters.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cur_seconds = 6'd5;
      sec_tick = 1'b1;
      cycle();
      sec_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic pulse(input logic snz, input logic dis);
    snooze = snz; dismiss = dis;
    cycle();
    snooze = 1'b0; dismiss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sec_tick = 1'b0; cur_hours = '0; cur_minutes = '0; cur_seconds = '0;
    wr_en = 1'b0; wr_sel = '0; dispMode = 1'b0; wr_isPM = 1'b0; wr_hours12 = '0;
    wr_hours24 = '0; wr_minutes = '0; snooze = 1'b0; dismiss = 1'b0; rd_sel = '0;
    cycle(); cycle();

    // Reset state: idle, with every slot disabled
    check_state("reset", 1'b0, 1'b0, 0);
    check("reset_fsm", 32'(fsm_state), 32'd0);
    for (int i = 0; i < 4; i++) check_rd("reset_rd", i, 24, 0);
    reset = 1'b0;
    cycle();

    // 12 AM in 12 h form is stored as hour 0; ringing starts after the match edge
    write12(1, 1'b0, 12, 30);
    check_rd("wr12_am12", 1, 0, 30);
    tick_at(0, 30, 0);
    check_state("ring_slot1", 1'b1, 1'b0, 1);
    pulse(1'b0, 1'b1);
    check_state("dismiss_ring", 1'b0, 1'b0, 0);

    // Two equal alarms: the lower index wins. A match while ringing is
    // ignored, and the ring auto-stops after 60 ticks.
    write24(2, 7, 15);
    write24(0, 7, 15);
    check_rd("wr24_slot2", 2, 7, 15);
    tick_at(7, 15, 0);
    check_state("lowest_wins", 1'b1, 1'b0, 0);
    tick_n(58);
    tick_at(0, 30, 0);
    check_state("match_in_ring_ignored", 1'b1, 1'b0, 0);
    tick_n(1);
    check_state("ring_timeout", 1'b0, 1'b0, 0);

    // 3 PM in 12 h form, then snooze for 300 ticks. Disabling the active
    // slot leaves the snooze running.
    write12(3, 1'b1, 3, 45);
    check_rd("wr12_pm3", 3, 15, 45);
    tick_at(15, 45, 0);
    check_state("ring_slot3", 1'b1, 1'b0, 3);
    pulse(1'b1, 1'b0);
    check_state("snoozed", 1'b0, 1'b1, 3);
    tick_n(299);
    check_state("snooze_299", 1'b0, 1'b1, 3);
    write24(3, 24, 0);
    check_state("disable_active", 1'b0, 1'b1, 3);
    check_rd("slot3_disabled", 3, 24, 0);
    tick_n(1);
    check_state("snooze_expire", 1'b1, 1'b0, 3);
    pulse(1'b1, 1'b1);
    check_state("dismiss_beats_snooze", 1'b0, 1'b0, 0);

    // Snooze and dismiss are ignored in IDLE
    pulse(1'b1, 1'b0);
    check_state("snooze_in_idle", 1'b0, 1'b0, 0);

    // A match while snoozed cancels the snooze and rings the new slot
    tick_at(7, 15, 0);
    pulse(1'b1, 1'b0);
    check_state("snooze_slot0", 1'b0, 1'b1, 0);
    tick_at(0, 30, 0);
    check_state("match_cancels_snooze", 1'b1, 1'b0, 1);
    pulse(1'b0, 1'b1);

    // Invalid writes leave the slot unchanged; 12 PM is stored as hour 12
    write12(2, 1'b0, 13, 10);
    write12(2, 1'b0, 0, 10);
    write24(2, 25, 10);
    write24(2, 8, 60);
    check_rd("invalid_writes", 2, 7, 15);
    write12(3, 1'b1, 12, 0);
    check_rd("wr12_pm12", 3, 12, 0);

    // A write and a match on the same slot in one cycle: the match uses the old value
    wr_en = 1'b1; wr_sel = 2'd1; dispMode = 1'b0; wr_hours24 = 5'd9; wr_minutes = 6'd0;
    tick_at(0, 30, 0);
    wr_en = 1'b0;
    check_state("write_match_same_cycle", 1'b1, 1'b0, 1);
    check_rd("write_match_rd", 1, 9, 0);
    pulse(1'b0, 1'b1);

    // Reset while snoozed drops to idle, and no ring follows
    tick_at(7, 15, 0);
    pulse(1'b1, 1'b0);
    tick_n(10);
    check_state("pre_reset_snooze", 1'b0, 1'b1, 0);
    reset = 1'b1;
    #1;
    check_state("async_reset", 1'b0, 1'b0, 0);
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) check_rd("post_reset_rd", i, 24, 0);
    tick_n(300);
    check_state("no_ring_after_reset", 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
